// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and read-valid controller turning a 16x8 dual-port RAM into a FIFO
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.

module fifo_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
`ifdef FIFO_CTRL_ERR_EN
  input  logic              err_clr,
  output logic              ovf_err,
  output logic              unf_err,
`endif
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
);

  localparam int              PW      = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = PW'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = PW'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = PW'(1);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            rd_valid_q, rd_valid_d;
  logic            push_acc, pop_acc;
  logic            unused_wrap;

  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    push_acc     = push & ~full & ~flush;
    pop_acc      = pop & ~empty & ~flush;
  end

  // Strobes are held low while reset is asserted so the RAM never sees a write during reset.
  assign ram_write   = push_acc & rst_n;
  assign ram_read    = pop_acc & rst_n;
  assign ram_wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign ram_rd_addr = rd_ptr_q[ADDR_W-1:0];
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;

  // Occupancy comes from count_q; the pointer wrap bits are kept only for debug visibility.
  assign unused_wrap = wr_ptr_q[ADDR_W] ^ rd_ptr_q[ADDR_W];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop_acc;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + ONE_C;
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error in the same cycle as err_clr wins over the clear.
  always_comb begin
    ovf_d = (push & full & ~flush) | (ovf_q & ~err_clr);
    unf_d = (pop & empty & ~flush) | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl with a queue-based reference FIFO and a behavioural RAM
// Builds with or without FIFO_CTRL_ERR_EN.

`timescale 1ns/1ps

module tb_fifo_ctrl;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n, push, pop, flush;
  logic          ram_write, ram_read, rd_valid;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic [7:0]    din, dout;
  logic [7:0]    mem [D];
`ifdef FIFO_CTRL_ERR_EN
  logic          err_clr, ovf_err, unf_err;
  bit            m_ovf, m_unf;
`endif

  int q[$];
  int wr_n, rd_n, m_data;
  bit m_rv;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit p, po, f;
    int cnt;
    bit wr, rd, rv;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
`ifdef FIFO_CTRL_ERR_EN
    .err_clr(err_clr), .ovf_err(ovf_err), .unf_err(unf_err),
`endif
    .ram_write(ram_write), .ram_wr_addr(ram_wr_addr),
    .ram_read(ram_read), .ram_rd_addr(ram_rd_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
  );

  always @(posedge clk) begin
    if (ram_write) mem[ram_wr_addr] <= din;
    if (ram_read)  dout <= mem[ram_rd_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    q.delete();
    wr_n = 0;
    rd_n = 0;
    m_rv = 0;
`ifdef FIFO_CTRL_ERR_EN
    m_ovf = 0;
    m_unf = 0;
`endif
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("count", count, sz);
    chk("full", full, sz == D);
    chk("empty", empty, sz == 0);
    chk("almost_full", almost_full, sz >= AF);
    chk("almost_empty", almost_empty, sz <= AE);
    chk("ram_write", ram_write, push && sz < D && !flush);
    chk("ram_read", ram_read, pop && sz > 0 && !flush);
    chk("wr_addr", ram_wr_addr, wr_n % D);
    chk("rd_addr", ram_rd_addr, rd_n % D);
    chk("rd_valid", rd_valid, m_rv);
    if (m_rv) chk("rd_data", dout, m_data);
`ifdef FIFO_CTRL_ERR_EN
    chk("ovf_err", ovf_err, m_ovf);
    chk("unf_err", unf_err, m_unf);
`endif
  endtask

  task automatic clock_model();
    int sz;
    bit pa, pr;
    @(posedge clk);
    sz = q.size();
    pa = push && sz < D && !flush;
    pr = pop && sz > 0 && !flush;
`ifdef FIFO_CTRL_ERR_EN
    m_ovf = (push && sz == D && !flush) || (m_ovf && !err_clr);
    m_unf = (pop && sz == 0 && !flush) || (m_unf && !err_clr);
`endif
    if (flush) begin
      q.delete();
      wr_n = 0;
      rd_n = 0;
      m_rv = 0;
    end else begin
      m_rv = pr;
      if (pr) begin
        m_data = q.pop_front();
        rd_n++;
      end
      if (pa) begin
        q.push_back(int'(din));
        wr_n++;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit p, input bit po, input bit f, input logic [7:0] d);
    push  = p;
    pop   = po;
    flush = f;
    din   = d;
    #1;
    check_model();
    clock_model();
  endtask

  initial begin
    tbl[0] = '{p:0, po:1, f:0, cnt:0, wr:0, rd:0, rv:0};
    tbl[1] = '{p:1, po:1, f:0, cnt:0, wr:1, rd:0, rv:0};
    tbl[2] = '{p:0, po:0, f:0, cnt:1, wr:0, rd:0, rv:0};
    tbl[3] = '{p:1, po:0, f:0, cnt:1, wr:1, rd:0, rv:0};
    tbl[4] = '{p:1, po:1, f:0, cnt:2, wr:1, rd:1, rv:0};
    tbl[5] = '{p:1, po:1, f:1, cnt:2, wr:0, rd:0, rv:1};
    tbl[6] = '{p:0, po:0, f:0, cnt:0, wr:0, rd:0, rv:0};

    rst_n = 1'b0;
    push  = 1'b1;
    pop   = 1'b1;
    flush = 1'b0;
    din   = '0;
`ifdef FIFO_CTRL_ERR_EN
    err_clr = 1'b0;
`endif
    model_reset();
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_addrs", {ram_wr_addr, ram_rd_addr}, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      push  = tbl[i].p;
      pop   = tbl[i].po;
      flush = tbl[i].f;
      din   = 8'(i + 8'h40);
      #1;
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_ram_write", ram_write, tbl[i].wr);
      chk("tbl_ram_read", ram_read, tbl[i].rd);
      chk("tbl_rd_valid", rd_valid, tbl[i].rv);
      check_model();
      clock_model();
    end

    for (int i = 0; i < D; i++) cyc(1, 0, 0, 8'(i));
    #1;
    chk("full_after_16", full, 1);
    @(negedge clk);
    cyc(1, 0, 0, 8'hAA);
    for (int i = 0; i < D; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
`ifdef FIFO_CTRL_ERR_EN
    err_clr = 1'b1;
    cyc(0, 0, 0, 8'h00);
    err_clr = 1'b0;
    cyc(0, 0, 0, 8'h00);
`endif

    for (int i = 0; i < D; i++) cyc(1, 0, 0, 8'(8'h80 + i));
    cyc(1, 1, 0, 8'hBB);
    for (int i = 0; i < D; i++) cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'hCC);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 5; i++)  cyc(1, 0, 0, 8'(8'h10 + i));
    for (int i = 5; i < 20; i++) cyc(1, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++)  cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    cyc(1, 1, 1, 8'hEE);
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 8'(8'h50 + i));
    push = 1'b1;
    #1;
    chk("pre_rst_count", count, 9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_aempty", almost_empty, 1);
    chk("async_rst_ram_write", ram_write, 0);
    chk("async_rst_wr_addr", ram_wr_addr, 0);
    model_reset();
    @(negedge clk);
    push  = 1'b0;
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 800; i++) begin
      bit p, po, f;
      bit heavy;
      heavy = ((i / 100) % 2) == 0;
      p  = $urandom_range(0, 3) < (heavy ? 3 : 1);
      po = $urandom_range(0, 3) < (heavy ? 1 : 3);
      f  = $urandom_range(0, 63) == 0;
`ifdef FIFO_CTRL_ERR_EN
      err_clr = $urandom_range(0, 15) == 0;
`endif
      cyc(p, po, f, 8'($urandom_range(0, 255)));
    end
`ifdef FIFO_CTRL_ERR_EN
    err_clr = 1'b0;
`endif
    cyc(0, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Sequencing controller that turns the team's 16x8 dual-port RAM into a synchronous FIFO. It owns the write and read pointers, drives the RAM's write, read, wr_addr and rd_addr inputs, and produces occupancy flags, a level count and a read-data-valid strobe. The RAM's 1-cycle registered read path is the FIFO data output; this block carries no data bits.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_W (16).
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
push  input  1  write request; the producer presents data directly on the RAM data_in.
pop  input  1  read request.
flush  input  1  synchronous clear of FIFO state.
ram_write  output  1  to RAM write; equals the accepted push (combinational).
ram_wr_addr  output  ADDR_W  to RAM wr_addr; equals wr_ptr[ADDR_W-1:0].
ram_read  output  1  to RAM read; equals the accepted pop (combinational).
ram_rd_addr  output  ADDR_W  to RAM rd_addr; equals rd_ptr[ADDR_W-1:0].
rd_valid  output  1  RAM data_out holds a newly popped word this cycle.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- State: wr_ptr and rd_ptr, each ADDR_W+1 bits, with the MSB as the wrap bit; count register; rd_valid register.
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0. Outputs during reset: empty=1, full=0, almost_empty=1, almost_full=0, ram_write=0, ram_read=0, addresses=0.
- Reset mid-operation discards all contents. RAM contents are not cleared and are never relied on.
- Acceptance:
  - push_acc = push & ~full & ~flush.
  - pop_acc = pop & ~empty & ~flush.
  - Flags are evaluated from registered state, so there is no same-cycle fall-through.
- Each edge:
  - push_acc: wr_ptr increments.
  - pop_acc: rd_ptr increments.
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo 2*DEPTH. Address outputs wrap 15 -> 0.
- ram_write and ram_read are purely combinational from push/pop, flags and flush. The RAM samples them on the same edge that advances the pointers.
- Read latency: rd_valid is registered from pop_acc and is high exactly 1 cycle after acceptance, aligned with the RAM's data_out update. Back-to-back pops give back-to-back rd_valid.
- Full boundary:
  - push when full is dropped, with no pointer or count change.
  - push and pop together when full: the pop is accepted and the push rejected; count goes DEPTH -> DEPTH-1.
- Empty boundary:
  - pop when empty is dropped and rd_valid stays 0.
  - push and pop together when empty: the push is accepted and the pop rejected; count goes 0 -> 1.
- flush has priority over push and pop. Next edge: pointers=0, count=0, rd_valid=0. ram_write and ram_read are 0 during the flush cycle.
- Flags are combinational decodes of the count register and change on the same edge as count.
- count never exceeds DEPTH and never underflows.

Optional Feature:
FIFO_CTRL_ERR_EN
- Defined:
  - Adds an input err_clr (1 bit) and outputs ovf_err and unf_err (1 bit each, sticky).
  - ovf_err is set on the edge after a push with full=1 and flush=0; unf_err likewise for a pop with empty=1.
  - err_clr clears both flags on the next edge; a set in the same cycle wins over the clear.
  - Both flags reset to 0 on rst_n.
- Undefined: the ports are absent and illegal requests are silently dropped.

Test Plan:
- Reset, then push 16 words (0x00..0x0F) -> count 16, full=1 after the 16th edge; almost_full first rises when count reaches 12; ram_wr_addr sequence 0..15.
- Pop 16 from full -> rd_valid high for 16 consecutive cycles starting 1 cycle after the first pop; RAM data_out 0x00..0x0F in order; empty=1 at the end; almost_empty rises at count 2.
- Push 20 then pop 20, interleaved so that occupancy stays at 5 -> addresses wrap 15 -> 0 on both ports; data order preserved; count steady at 5 during the simultaneous push/pop phase.
- Simultaneous push+pop at count 16 -> count 15, ram_write=0, ram_read=1. The same at count 0 -> count 1, ram_read=0, no rd_valid.
- flush asserted at count 7 together with push and pop -> ram_write=0 and ram_read=0 that cycle; next cycle count=0, empty=1, both addresses 0, rd_valid=0.
- rst_n pulled low mid-burst at count 9, asynchronously between edges -> flags reset immediately with no clock edge (empty=1, count=0). With FIFO_CTRL_ERR_EN: push at full sets ovf_err, pop at empty sets unf_err, err_clr clears both.
